// File: rtl/gx_latopt_rst_seq.sv
// Reset sequencer for NUM_CH latency-optimised GX channels: one bonded TX FSM, one RX FSM per channel.
// Defining GX_RST_LOSS_CNT_EN adds the per-channel rx_loss_cnt output (8-bit saturating lock-loss counters).
module gx_latopt_rst_seq #(
    parameter int NUM_CH     = 3,
    parameter int ANA_MIN    = 16,
    parameter int DIG_DLY    = 64,
    parameter int LTD_STABLE = 1024,
    parameter int LTD_TMO    = 65536,
    parameter int CNT_W      = 20
) (
    input  logic              reconfig_clk,
    input  logic              reconfig_reset_n,
    input  logic              tx_pll_locked,
    input  logic [NUM_CH-1:0] tx_cal_busy,
    input  logic [NUM_CH-1:0] rx_cal_busy,
    input  logic [NUM_CH-1:0] rx_is_lockedtodata,
    input  logic              tx_reset_req,
    input  logic [NUM_CH-1:0] rx_reset_req,
    output logic [NUM_CH-1:0] tx_analogreset,
    output logic [NUM_CH-1:0] tx_digitalreset,
    output logic [NUM_CH-1:0] rx_analogreset,
    output logic [NUM_CH-1:0] rx_digitalreset,
    output logic              tx_ready,
    output logic [NUM_CH-1:0] rx_ready
`ifdef GX_RST_LOSS_CNT_EN
    ,
    output logic [NUM_CH*8-1:0] rx_loss_cnt
`endif
);

    localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);
    localparam logic [CNT_W-1:0] ANA_MIN_C  = CNT_W'(ANA_MIN);
    localparam logic [CNT_W-1:0] DIG_LAST_C = CNT_W'(DIG_DLY - 1);
    localparam logic [CNT_W-1:0] STABLE_C   = CNT_W'(LTD_STABLE);
    localparam logic [CNT_W-1:0] TMO_LAST_C = CNT_W'(LTD_TMO - 1);

    typedef enum logic [1:0] {TX_ANA = 2'd0, TX_DIG = 2'd1, TX_READY = 2'd2} tx_state_e;
    typedef enum logic [1:0] {RX_ANA = 2'd0, RX_LTD = 2'd1, RX_READY = 2'd2} rx_state_e;

    // Cal-busy synchronisers reset to busy so nothing is released before real status arrives.
    logic              pll_m_q, pll_s_q;
    logic [NUM_CH-1:0] txcal_m_q, txcal_s_q, rxcal_m_q, rxcal_s_q, ltd_m_q, ltd_s_q;

    always_ff @(posedge reconfig_clk or negedge reconfig_reset_n) begin
        if (!reconfig_reset_n) begin
            pll_m_q   <= 1'b0;
            pll_s_q   <= 1'b0;
            txcal_m_q <= '1;
            txcal_s_q <= '1;
            rxcal_m_q <= '1;
            rxcal_s_q <= '1;
            ltd_m_q   <= '0;
            ltd_s_q   <= '0;
        end else begin
            pll_m_q   <= tx_pll_locked;
            pll_s_q   <= pll_m_q;
            txcal_m_q <= tx_cal_busy;
            txcal_s_q <= txcal_m_q;
            rxcal_m_q <= rx_cal_busy;
            rxcal_s_q <= rxcal_m_q;
            ltd_m_q   <= rx_is_lockedtodata;
            ltd_s_q   <= ltd_m_q;
        end
    end

    tx_state_e        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic             tx_ana_q, tx_ana_d, tx_dig_q, tx_dig_d, tx_rdy_q, tx_rdy_d;

    always_ff @(posedge reconfig_clk or negedge reconfig_reset_n) begin
        if (!reconfig_reset_n) begin
            tx_state_q <= TX_ANA;
            tx_cnt_q   <= '0;
            tx_ana_q   <= 1'b1;
            tx_dig_q   <= 1'b1;
            tx_rdy_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_ana_q   <= tx_ana_d;
            tx_dig_q   <= tx_dig_d;
            tx_rdy_q   <= tx_rdy_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        case (tx_state_q)
            TX_ANA: begin
                if (tx_reset_req) begin
                    tx_cnt_d = '0;
                end else if (tx_cnt_q >= ANA_MIN_C && pll_s_q && !(|txcal_s_q)) begin
                    tx_state_d = TX_DIG;
                    tx_cnt_d   = '0;
                end else if (tx_cnt_q < ANA_MIN_C) begin
                    tx_cnt_d = tx_cnt_q + ONE_C;
                end
            end
            TX_DIG: begin
                if (!pll_s_q || tx_reset_req) begin
                    tx_state_d = TX_ANA;
                    tx_cnt_d   = '0;
                end else if (tx_cnt_q >= DIG_LAST_C) begin
                    tx_state_d = TX_READY;
                    tx_cnt_d   = '0;
                end else begin
                    tx_cnt_d = tx_cnt_q + ONE_C;
                end
            end
            TX_READY: begin
                if (!pll_s_q || tx_reset_req) begin
                    tx_state_d = TX_ANA;
                    tx_cnt_d   = '0;
                end
            end
            default: begin
                tx_state_d = TX_ANA;
                tx_cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        tx_ana_d = (tx_state_q == TX_ANA);
        tx_dig_d = (tx_state_q != TX_READY);
        tx_rdy_d = (tx_state_q == TX_READY);
    end

    assign tx_analogreset  = {NUM_CH{tx_ana_q}};
    assign tx_digitalreset = {NUM_CH{tx_dig_q}};
    assign tx_ready        = tx_rdy_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_rx
        rx_state_e        state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d, stb_q, stb_d, stb_inc;
        logic             ana_q, ana_d, dig_q, dig_d, rdy_q, rdy_d;

        assign stb_inc = (stb_q >= STABLE_C) ? stb_q : stb_q + ONE_C;

        always_ff @(posedge reconfig_clk or negedge reconfig_reset_n) begin
            if (!reconfig_reset_n) begin
                state_q <= RX_ANA;
                cnt_q   <= '0;
                stb_q   <= '0;
                ana_q   <= 1'b1;
                dig_q   <= 1'b1;
                rdy_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                stb_q   <= stb_d;
                ana_q   <= ana_d;
                dig_q   <= dig_d;
                rdy_q   <= rdy_d;
            end
        end

        // cnt measures time in the current state: analog hold in RX_ANA, timeout in RX_LTD.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            stb_d   = stb_q;
            case (state_q)
                RX_ANA: begin
                    if (rx_reset_req[i]) begin
                        cnt_d = '0;
                    end else if (cnt_q >= ANA_MIN_C && !rxcal_s_q[i]) begin
                        state_d = RX_LTD;
                        cnt_d   = '0;
                        stb_d   = '0;
                    end else if (cnt_q < ANA_MIN_C) begin
                        cnt_d = cnt_q + ONE_C;
                    end
                end
                RX_LTD: begin
                    if (rx_reset_req[i]) begin
                        state_d = RX_ANA;
                        cnt_d   = '0;
                    end else begin
                        stb_d = ltd_s_q[i] ? stb_inc : '0;
                        if (ltd_s_q[i] && stb_inc >= STABLE_C) begin
                            state_d = RX_READY;
                            cnt_d   = '0;
                        end else if (cnt_q >= TMO_LAST_C) begin
                            state_d = RX_ANA;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + ONE_C;
                        end
                    end
                end
                RX_READY: begin
                    if (rx_reset_req[i]) begin
                        state_d = RX_ANA;
                        cnt_d   = '0;
                    end else if (!ltd_s_q[i]) begin
                        state_d = RX_LTD;
                        cnt_d   = '0;
                        stb_d   = '0;
                    end
                end
                default: begin
                    state_d = RX_ANA;
                    cnt_d   = '0;
                end
            endcase
        end

        always_comb begin
            ana_d = (state_q == RX_ANA);
            dig_d = (state_q != RX_READY);
            rdy_d = (state_q == RX_READY);
        end

        assign rx_analogreset[i]  = ana_q;
        assign rx_digitalreset[i] = dig_q;
        assign rx_ready[i]        = rdy_q;

`ifdef GX_RST_LOSS_CNT_EN
        logic       loss_ev;
        logic [7:0] loss_q;

        assign loss_ev = (state_q == RX_READY && state_d == RX_LTD) ||
                         (state_q == RX_LTD && state_d == RX_ANA && !rx_reset_req[i]);

        always_ff @(posedge reconfig_clk or negedge reconfig_reset_n) begin
            if (!reconfig_reset_n) begin
                loss_q <= '0;
            end else if (rx_reset_req[i]) begin
                loss_q <= '0;
            end else if (loss_ev && loss_q != 8'hFF) begin
                loss_q <= loss_q + 8'd1;
            end
        end

        assign rx_loss_cnt[i*8 +: 8] = loss_q;
`endif
    end

endmodule

// File: tb/tb_gx_latopt_rst_seq.sv
// Bench for gx_latopt_rst_seq: directed scenarios plus random status traffic, every cycle checked
// against a behavioural model built from the sequencing rules (phases, elapsed time, stable runs).
module tb_gx_latopt_rst_seq;
    localparam int NUM_CH     = 3;
    localparam int ANA_MIN    = 4;
    localparam int DIG_DLY    = 8;
    localparam int LTD_STABLE = 16;
    localparam int LTD_TMO    = 64;
    localparam int PH_ANA = 0, PH_MID = 1, PH_RDY = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              tx_pll_locked = 1'b1;
    logic [NUM_CH-1:0] tx_cal_busy = '0;
    logic [NUM_CH-1:0] rx_cal_busy = '0;
    logic [NUM_CH-1:0] rx_is_lockedtodata = '1;
    logic              tx_reset_req = 1'b0;
    logic [NUM_CH-1:0] rx_reset_req = '0;
    logic [NUM_CH-1:0] tx_analogreset, tx_digitalreset, rx_analogreset, rx_digitalreset, rx_ready;
    logic              tx_ready;
`ifdef GX_RST_LOSS_CNT_EN
    logic [NUM_CH*8-1:0] rx_loss_cnt;
`endif

    always #5 clk = ~clk;

    gx_latopt_rst_seq #(
        .NUM_CH(NUM_CH), .ANA_MIN(ANA_MIN), .DIG_DLY(DIG_DLY),
        .LTD_STABLE(LTD_STABLE), .LTD_TMO(LTD_TMO), .CNT_W(20)
    ) dut (
        .reconfig_clk(clk),
        .reconfig_reset_n(rst_n),
        .tx_pll_locked(tx_pll_locked),
        .tx_cal_busy(tx_cal_busy),
        .rx_cal_busy(rx_cal_busy),
        .rx_is_lockedtodata(rx_is_lockedtodata),
        .tx_reset_req(tx_reset_req),
        .rx_reset_req(rx_reset_req),
        .tx_analogreset(tx_analogreset),
        .tx_digitalreset(tx_digitalreset),
        .rx_analogreset(rx_analogreset),
        .rx_digitalreset(rx_digitalreset),
        .tx_ready(tx_ready),
        .rx_ready(rx_ready)
`ifdef GX_RST_LOSS_CNT_EN
        ,
        .rx_loss_cnt(rx_loss_cnt)
`endif
    );

    int n_assert = 0;
    int n_fail   = 0;
    string phase_tag = "init";

    // Reference model: synchroniser history, phase per FSM, elapsed cycles, stable-lock run length.
    logic              m_pll1, m_pll2;
    logic [NUM_CH-1:0] m_tcal1, m_tcal2, m_rcal1, m_rcal2, m_ltd1, m_ltd2;
    int                tx_ph, tx_age;
    int                rx_ph [NUM_CH];
    int                rx_age[NUM_CH];
    int                rx_run[NUM_CH];
    int                rx_loss[NUM_CH];
    logic              e_tx_ana, e_tx_dig, e_tx_rdy;
    logic [NUM_CH-1:0] e_rx_ana, e_rx_dig, e_rx_rdy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pll1 = 1'b0; m_pll2 = 1'b0;
        m_tcal1 = '1; m_tcal2 = '1; m_rcal1 = '1; m_rcal2 = '1;
        m_ltd1 = '0; m_ltd2 = '0;
        tx_ph = PH_ANA; tx_age = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            rx_ph[i] = PH_ANA; rx_age[i] = 0; rx_run[i] = 0; rx_loss[i] = 0;
        end
        e_tx_ana = 1'b1; e_tx_dig = 1'b1; e_tx_rdy = 1'b0;
        e_rx_ana = '1; e_rx_dig = '1; e_rx_rdy = '0;
    endtask

    task automatic model_step();
        bit lost;
        e_tx_ana = (tx_ph == PH_ANA);
        e_tx_dig = (tx_ph != PH_RDY);
        e_tx_rdy = (tx_ph == PH_RDY);
        for (int i = 0; i < NUM_CH; i++) begin
            e_rx_ana[i] = (rx_ph[i] == PH_ANA);
            e_rx_dig[i] = (rx_ph[i] != PH_RDY);
            e_rx_rdy[i] = (rx_ph[i] == PH_RDY);
        end
        if (tx_ph == PH_ANA) begin
            if (tx_reset_req) tx_age = 0;
            else if (tx_age >= ANA_MIN && m_pll2 && m_tcal2 == 0) begin tx_ph = PH_MID; tx_age = 0; end
            else tx_age++;
        end else if (!m_pll2 || tx_reset_req) begin
            tx_ph = PH_ANA; tx_age = 0;
        end else if (tx_ph == PH_MID) begin
            if (tx_age + 1 >= DIG_DLY) begin tx_ph = PH_RDY; tx_age = 0; end
            else tx_age++;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            lost = 0;
            if (rx_reset_req[i]) begin
                if (rx_ph[i] != PH_ANA) rx_ph[i] = PH_ANA;
                rx_age[i] = 0;
            end else if (rx_ph[i] == PH_ANA) begin
                if (rx_age[i] >= ANA_MIN && !m_rcal2[i]) begin rx_ph[i] = PH_MID; rx_age[i] = 0; rx_run[i] = 0; end
                else rx_age[i]++;
            end else if (rx_ph[i] == PH_MID) begin
                rx_run[i] = m_ltd2[i] ? rx_run[i] + 1 : 0;
                if (rx_run[i] >= LTD_STABLE) rx_ph[i] = PH_RDY;
                else if (rx_age[i] + 1 >= LTD_TMO) begin rx_ph[i] = PH_ANA; rx_age[i] = 0; lost = 1; end
                else rx_age[i]++;
            end else if (!m_ltd2[i]) begin
                rx_ph[i] = PH_MID; rx_age[i] = 0; rx_run[i] = 0; lost = 1;
            end
            if (rx_reset_req[i]) rx_loss[i] = 0;
            else if (lost && rx_loss[i] < 255) rx_loss[i]++;
        end
        m_pll2 = m_pll1;   m_pll1 = tx_pll_locked;
        m_tcal2 = m_tcal1; m_tcal1 = tx_cal_busy;
        m_rcal2 = m_rcal1; m_rcal1 = rx_cal_busy;
        m_ltd2 = m_ltd1;   m_ltd1 = rx_is_lockedtodata;
    endtask

    task automatic check_all();
        logic [NUM_CH*8-1:0] e_loss;
        chk({phase_tag, ".tx_analogreset"}, 32'(tx_analogreset), 32'({NUM_CH{e_tx_ana}}));
        chk({phase_tag, ".tx_digitalreset"}, 32'(tx_digitalreset), 32'({NUM_CH{e_tx_dig}}));
        chk({phase_tag, ".tx_ready"}, 32'(tx_ready), 32'(e_tx_rdy));
        chk({phase_tag, ".rx_analogreset"}, 32'(rx_analogreset), 32'(e_rx_ana));
        chk({phase_tag, ".rx_digitalreset"}, 32'(rx_digitalreset), 32'(e_rx_dig));
        chk({phase_tag, ".rx_ready"}, 32'(rx_ready), 32'(e_rx_rdy));
        for (int i = 0; i < NUM_CH; i++) e_loss[i*8 +: 8] = 8'(rx_loss[i]);
`ifdef GX_RST_LOSS_CNT_EN
        chk({phase_tag, ".rx_loss_cnt"}, 32'(rx_loss_cnt), 32'(e_loss));
`endif
    endtask

    // One clock: model consumes pre-edge inputs, DUT samples #1 after the edge.
    task automatic tick();
        if (!rst_n) model_reset();
        else model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, ".tx_ana"}, 32'(tx_analogreset), 32'h7);
        chk({tag, ".tx_dig"}, 32'(tx_digitalreset), 32'h7);
        chk({tag, ".tx_rdy"}, 32'(tx_ready), 32'h0);
        chk({tag, ".rx_ana"}, 32'(rx_analogreset), 32'h7);
        chk({tag, ".rx_dig"}, 32'(rx_digitalreset), 32'h7);
        chk({tag, ".rx_rdy"}, 32'(rx_ready), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t_tx, t_rx, retries;
        bit ch1_held, ch2_seen_rdy, saw_dig, ana_low, rx_kept, prev_ana2;

        model_reset();
        phase_tag = "reset";
        ticks(3);
        chk_reset_values("reset_values");

        phase_tag = "bringup";
        rst_n = 1'b1;
        t_tx = 999; t_rx = 999;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (tx_ready && t_tx == 999) t_tx = c;
            if (rx_ready == 3'b111 && t_rx == 999) t_rx = c;
        end
        chk("tx_ready_latency_ok", 32'(t_tx <= 2 + ANA_MIN + DIG_DLY + 3), 32'd1);
        chk("rx_ready_latency_ok", 32'(t_rx <= 2 + ANA_MIN + LTD_STABLE + 3), 32'd1);

        phase_tag = "cal_busy_ch1";
        rst_n = 1'b0;
        rx_cal_busy = 3'b010;
        ticks(2);
        rst_n = 1'b1;
        ch1_held = 1;
        for (int c = 0; c < 100; c++) begin
            tick();
            ch1_held &= rx_analogreset[1];
        end
        chk("ch1_ana_held_while_cal", 32'(ch1_held), 32'd1);
        chk("ch0_ch2_ready_while_ch1_cal", 32'(rx_ready), 32'b101);
        rx_cal_busy = '0;
        ticks(30);
        chk("ch1_ready_after_cal", 32'(rx_ready), 32'b111);

        phase_tag = "ch2_toggle";
        ch2_seen_rdy = 0; retries = 0; prev_ana2 = rx_analogreset[2];
        for (int c = 0; c < 200; c++) begin
            if (c % 10 == 0) rx_is_lockedtodata[2] = ~rx_is_lockedtodata[2];
            tick();
            if (c > 4) ch2_seen_rdy |= rx_ready[2];
            if (rx_analogreset[2] && !prev_ana2) retries++;
            prev_ana2 = rx_analogreset[2];
        end
        chk("ch2_never_ready_toggling", 32'(ch2_seen_rdy), 32'd0);
        chk("ch2_timeout_retries_ge2", 32'(retries >= 2), 32'd1);
        rx_is_lockedtodata[2] = 1'b1;
        ticks(40);
        chk("ch2_ready_after_stable", 32'(rx_ready), 32'b111);

        phase_tag = "ch0_glitch";
        rx_is_lockedtodata[0] = 1'b0;
        tick();
        rx_is_lockedtodata[0] = 1'b1;
        saw_dig = 0; ana_low = 1;
        for (int c = 0; c < 3; c++) begin
            tick();
            saw_dig |= rx_digitalreset[0];
            ana_low &= ~rx_analogreset[0];
        end
        chk("ch0_dig_within_3", 32'(saw_dig), 32'd1);
        for (int c = 0; c < 25; c++) begin
            tick();
            ana_low &= ~rx_analogreset[0];
        end
        chk("ch0_ana_stays_low", 32'(ana_low), 32'd1);
        chk("ch0_re_ready", 32'(rx_ready[0]), 32'd1);

        phase_tag = "pll_loss";
        tx_pll_locked = 1'b0;
        rx_kept = 1;
        for (int c = 0; c < 4; c++) begin
            tick();
            rx_kept &= (rx_ready == 3'b111);
        end
        chk("pll_loss_tx_ana", 32'(tx_analogreset), 32'h7);
        chk("pll_loss_tx_dig", 32'(tx_digitalreset), 32'h7);
        chk("pll_loss_tx_ready", 32'(tx_ready), 32'h0);
        for (int c = 0; c < 10; c++) begin
            tick();
            rx_kept &= (rx_ready == 3'b111);
        end
        chk("pll_loss_rx_unaffected", 32'(rx_kept), 32'd1);
        tx_pll_locked = 1'b1;
        ticks(25);
        chk("tx_ready_after_relock", 32'(tx_ready), 32'd1);

        phase_tag = "reset_req";
        tx_reset_req = 1'b1; rx_reset_req = 3'b100;
        ticks(2);
        rx_reset_req = '0;
        tick();
        tx_reset_req = 1'b0;
        ticks(35);
        chk("ready_after_reqs", 32'({tx_ready, rx_ready}), 32'hF);

        phase_tag = "random";
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 149) == 0) tx_pll_locked = ~tx_pll_locked;
            if ($urandom_range(0, 99) == 0)
                tx_cal_busy = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            if ($urandom_range(0, 99) == 0)
                rx_cal_busy = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            for (int i = 0; i < NUM_CH; i++) begin
                if ($urandom_range(0, 39) == 0) rx_is_lockedtodata[i] = ~rx_is_lockedtodata[i];
                rx_reset_req[i] = ($urandom_range(0, 149) == 0);
            end
            tx_reset_req = ($urandom_range(0, 199) == 0);
            if (c == 400) begin
                #2;
                rst_n = 1'b0;
                #1;
                chk_reset_values("mid_async_reset");
                ticks(2);
                rst_n = 1'b1;
            end
            tick();
        end

        phase_tag = "settle";
        tx_pll_locked = 1'b1; tx_cal_busy = '0; rx_cal_busy = '0;
        rx_is_lockedtodata = '1; tx_reset_req = 1'b0; rx_reset_req = '0;
        ticks(90);
        chk("all_ready_after_random", 32'({tx_ready, rx_ready}), 32'hF);

`ifdef GX_RST_LOSS_CNT_EN
        phase_tag = "loss_cnt";
        rx_reset_req[1] = 1'b1;
        tick();
        rx_reset_req[1] = 1'b0;
        for (int n = 0; n < 300; n++) begin
            for (int w = 0; w < 60 && rx_ready[1] !== 1'b1; w++) tick();
            chk("ch1_ready_before_drop", 32'(rx_ready[1]), 32'd1);
            rx_is_lockedtodata[1] = 1'b0;
            tick();
            rx_is_lockedtodata[1] = 1'b1;
        end
        ticks(5);
        chk("loss_cnt_saturated", 32'(rx_loss_cnt[15:8]), 32'd255);
        rx_reset_req[1] = 1'b1;
        tick();
        rx_reset_req[1] = 1'b0;
        tick();
        chk("loss_cnt_cleared", 32'(rx_loss_cnt[15:8]), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
